ntt_frame_serializer: RTL and testbench
=======================================

NTT_FRAME_SERIALIZER -- requirements
Module: ntt_frame_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_PER_INPUT, default 28, width of one coefficient.
REQ-002 SHALL have parameter INPUT_PER_CYCLE, default 64, coefficients per parallel frame; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port par_start, input, 1, one-cycle strobe marking par_data as a valid NTT output frame.
REQ-006 SHALL have port par_data, input, INPUT_PER_CYCLE x DATA_WIDTH_PER_INPUT unpacked array, the parallel frame; index 0 is sent first.
REQ-007 SHALL have port ser_valid, output, 1, ser_data/ser_first/ser_last hold a valid word.
REQ-008 SHALL have port ser_ready, input, 1, downstream accepts the word; a transfer occurs when ser_valid and ser_ready are both high.
REQ-009 SHALL have port ser_data, output, DATA_WIDTH_PER_INPUT, the current coefficient.
REQ-010 SHALL have port ser_first, output, 1, high with word index 0 of a frame.
REQ-011 SHALL have port ser_last, output, 1, high with word index INPUT_PER_CYCLE-1 of a frame.
REQ-012 SHALL have port overflow, output, 1, sticky flag: a frame was dropped.
REQ-013 SHALL have port overflow_clr, input, 1, clears overflow.
REQ-014 SHALL have port busy, output, 1, high when at least one bank holds an untransmitted frame.

Function
REQ-015 SHALL hold two frame banks (ping-pong), each INPUT_PER_CYCLE x DATA_WIDTH_PER_INPUT, plus a per-bank full bit.
REQ-016 SHALL capture par_data into the write-pointer bank on par_start when that bank's full bit, as registered at the start of the cycle, is clear; SHALL then set the bit and toggle the write pointer.
REQ-017 SHALL drop a frame whose par_start arrives while both banks are full, leave both banks unchanged and set overflow on the next edge.
REQ-018 SHALL NOT let a bank freed by a transfer in cycle t accept a par_start in the same cycle t; the bank is available from cycle t+1.
REQ-019 SHALL run a read FSM with states IDLE and STREAM: IDLE->STREAM when the read-pointer bank is full; STREAM->IDLE after the ser_last transfer when the other bank is empty; STREAM stays in STREAM when the other bank is full, with the next frame's word 0 presented the cycle after ser_last transfers (no bubble).
REQ-020 SHALL present word 0 on the rising edge following the capture edge; minimum latency from par_start to ser_valid is 2 clock edges (capture edge, then output-register edge).
REQ-021 SHALL drive ser_data, ser_first and ser_last from registers; these and ser_valid SHALL remain stable while ser_valid is high and ser_ready is low.
REQ-022 SHALL advance the word index (log2(INPUT_PER_CYCLE) bits) only on a transfer; on the ser_last transfer it SHALL wrap to 0, clear the bank's full bit and toggle the read pointer.
REQ-023 SHALL give precedence to set over clear when par_start-drop and overflow_clr occur in the same cycle: overflow stays high.
REQ-024 SHALL pass data unmodified; no arithmetic on coefficients.

Reset
REQ-025 SHALL, while rst is high, set ser_valid, ser_first, ser_last, overflow, busy, both full bits, both pointers and the word index to 0, set ser_data to 0 and set the FSM to IDLE; bank contents need not be reset.
REQ-026 SHALL discard any partially transmitted frame when rst is asserted mid-stream; after reset the next transfer starts with a fresh frame's word 0.

Structure
REQ-027 SHALL take the default parameter values and the FSM state enum from the shared NTT package used by the NTT top level.
REQ-028 SHALL be implemented as this module plus one sub-module, ntt_frame_bank, holding one bank with a write-all port and an indexed read port, instantiated twice.

Verification
REQ-029 SHALL verify single frame, ser_ready tied high: par_start with par_data[i]=i+100 -> words 100..163 on consecutive cycles, ser_first on 100, ser_last on 163, overflow 0.
REQ-030 SHALL verify backpressure: ser_ready toggled 1,0,0,1 repeating -> all 64 words in order, with no duplicates, and outputs stable during stalls.
REQ-031 SHALL verify back-to-back: two par_start strobes 3 cycles apart -> 128 contiguous words, second frame's word 0 directly after the first ser_last, busy low after the final transfer.
REQ-032 SHALL verify overflow: ser_ready low, three par_start strobes -> overflow=1, first two frames later delivered intact; overflow_clr -> overflow=0.
REQ-033 SHALL verify the same-cycle boundary: par_start in the cycle of the last transfer with both banks full -> frame dropped, overflow=1.
REQ-034 SHALL verify reset: rst asserted at word 20 -> next cycle ser_valid=0, busy=0; a new frame then starts with ser_first.

Source files
------------

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT defaults and serializer read-FSM state type
package ntt_pkg;

    localparam int NTT_DATA_WIDTH      = 28;
    localparam int NTT_INPUT_PER_CYCLE = 64;

    typedef enum logic {
        SER_IDLE   = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ntt_frame_bank.sv
// rtl/ntt_frame_bank.sv - one frame of coefficients, written whole, read one word at a time
module ntt_frame_bank
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = NTT_DATA_WIDTH,
    parameter int DEPTH      = NTT_INPUT_PER_CYCLE,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data [DEPTH],
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ntt_frame_serializer.sv
// rtl/ntt_frame_serializer.sv - ping-pong buffered parallel-to-serial converter for NTT output frames
module ntt_frame_serializer
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = NTT_DATA_WIDTH,
    parameter int INPUT_PER_CYCLE      = NTT_INPUT_PER_CYCLE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            par_start,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] par_data [INPUT_PER_CYCLE],
    output logic                            ser_valid,
    input  logic                            ser_ready,
    output logic [DATA_WIDTH_PER_INPUT-1:0] ser_data,
    output logic                            ser_first,
    output logic                            ser_last,
    output logic                            overflow,
    input  logic                            overflow_clr,
    output logic                            busy
);

    localparam int IDX_W = $clog2(INPUT_PER_CYCLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_PER_CYCLE - 1);

    ser_state_t                      state;
    logic [1:0]                      full;
    logic [1:0]                      full_n;
    logic                            wr_ptr;
    logic                            rd_ptr;
    logic [IDX_W-1:0]                idx;
    logic [IDX_W-1:0]                idx_inc;
    logic                            xfer;
    logic                            frame_done;
    logic                            accept;
    logic                            drop;
    logic                            bank_we  [2];
    logic [IDX_W-1:0]                bank_idx [2];
    logic [DATA_WIDTH_PER_INPUT-1:0] bank_rd  [2];

    assign xfer       = ser_valid && ser_ready;
    assign frame_done = xfer && ser_last;
    assign idx_inc    = idx + 1'b1;
    // Full bits are judged as registered, so a bank freed this cycle is not reusable until next cycle.
    assign accept     = par_start && !full[wr_ptr];
    assign drop       = par_start && (&full);

    always_comb begin
        full_n = full;
        if (frame_done) full_n[rd_ptr] = 1'b0;
        if (accept)     full_n[wr_ptr] = 1'b1;
    end

    // The streaming bank is addressed one word ahead; the idle bank always exposes word 0 for a seamless handoff.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b]  = accept && (wr_ptr == 1'(b));
        assign bank_idx[b] = (state == SER_STREAM && rd_ptr == 1'(b)) ? idx_inc : '0;

        ntt_frame_bank #(
            .DATA_WIDTH (DATA_WIDTH_PER_INPUT),
            .DEPTH      (INPUT_PER_CYCLE)
        ) u_bank (
            .clk     (clk),
            .wr_en   (bank_we[b]),
            .wr_data (par_data),
            .rd_idx  (bank_idx[b]),
            .rd_data (bank_rd[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SER_IDLE;
            full      <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            idx       <= '0;
            ser_valid <= 1'b0;
            ser_data  <= '0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            full <= full_n;
            busy <= |full_n;
            if (accept) wr_ptr <= ~wr_ptr;
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;

            case (state)
                SER_IDLE: begin
                    if (full[rd_ptr]) begin
                        ser_valid <= 1'b1;
                        ser_data  <= bank_rd[rd_ptr];
                        ser_first <= 1'b1;
                        ser_last  <= 1'b0;
                        idx       <= '0;
                        state     <= SER_STREAM;
                    end
                end
                SER_STREAM: begin
                    if (xfer) begin
                        if (ser_last) begin
                            idx    <= '0;
                            rd_ptr <= ~rd_ptr;
                            if (full[~rd_ptr]) begin
                                ser_data  <= bank_rd[~rd_ptr];
                                ser_first <= 1'b1;
                                ser_last  <= 1'b0;
                            end else begin
                                ser_valid <= 1'b0;
                                ser_first <= 1'b0;
                                ser_last  <= 1'b0;
                                state     <= SER_IDLE;
                            end
                        end else begin
                            idx       <= idx_inc;
                            ser_data  <= bank_rd[rd_ptr];
                            ser_first <= 1'b0;
                            ser_last  <= (idx_inc == LAST_IDX);
                        end
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_frame_serializer.sv
// tb/tb_ntt_frame_serializer.sv - self-checking bench for ntt_frame_serializer
module tb_ntt_frame_serializer;

    localparam int DW = 28;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          par_start = 1'b0;
    logic [DW-1:0] par_data [N];
    logic          ser_valid;
    logic          ser_ready = 1'b0;
    logic [DW-1:0] ser_data;
    logic          ser_first;
    logic          ser_last;
    logic          overflow;
    logic          overflow_clr = 1'b0;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Model: pending words in send order, per-frame first-visible edge, position inside head frame.
    logic [DW-1:0] exp_q [$];
    int            fr_avail [$];
    int            pos = 0;
    logic          m_ovf = 1'b0;
    logic          was_rst = 1'b1;
    logic [DW-1:0] got_q [$];

    ntt_frame_serializer #(
        .DATA_WIDTH_PER_INPUT (DW),
        .INPUT_PER_CYCLE      (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .par_start    (par_start),
        .par_data     (par_data),
        .ser_valid    (ser_valid),
        .ser_ready    (ser_ready),
        .ser_data     (ser_data),
        .ser_first    (ser_first),
        .ser_last     (ser_last),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic exp_valid;
        logic m_drop;
        int   held;
        exp_valid = (fr_avail.size() > 0) && (fr_avail[0] <= edge_n);
        chk("ser_valid", ser_valid, exp_valid);
        if (exp_valid) begin
            chk("ser_data", ser_data, exp_q[0]);
            chk("ser_first", ser_first, pos == 0);
            chk("ser_last", ser_last, pos == N - 1);
        end
        if (was_rst) begin
            chk("rst_data", ser_data, 0);
            chk("rst_first", ser_first, 0);
            chk("rst_last", ser_last, 0);
        end
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, fr_avail.size() > 0);

        was_rst = rst;
        if (rst) begin
            exp_q.delete();
            fr_avail.delete();
            pos   = 0;
            m_ovf = 1'b0;
        end else begin
            held   = fr_avail.size();
            m_drop = par_start && (held >= 2);
            if (m_drop)            m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            if (par_start && !m_drop) begin
                for (int i = 0; i < N; i++) exp_q.push_back(par_data[i]);
                fr_avail.push_back(edge_n + 2);
            end
            if (ser_valid && ser_ready) got_q.push_back(ser_data);
            if (exp_valid && ser_ready) begin
                void'(exp_q.pop_front());
                pos++;
                if (pos == N) begin
                    pos = 0;
                    void'(fr_avail.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int base, input int step);
        for (int i = 0; i < N; i++) par_data[i] = DW'(base + i * step);
        par_start = 1'b1;
    endtask

    task automatic send_frame(input int base, input int step);
        load_frame(base, step);
        tick();
        par_start = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, got_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk("drain_idle", busy, 0);
    endtask

    initial begin : stim
        int k;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < N; i++) par_data[i] = '0;

        repeat (3) tick();
        chk("reset_valid", ser_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", overflow, 0);
        rst = 1'b0;
        tick();

        // single frame, ready high
        got_q.delete();
        ser_ready = 1'b1;
        send_frame(100, 1);
        chk("lat_not_yet", ser_valid, 0);
        tick();
        chk("lat_valid", ser_valid, 1);
        chk("lat_word0", ser_data, 100);
        chk("lat_first", ser_first, 1);
        wait_words(N, 200, "single_count");
        chk("single_w0", got_q[0], 100);
        chk("single_w63", got_q[63], 163);
        chk("single_busy", busy, 0);
        chk("single_ovf", overflow, 0);

        // backpressure 1,0,0,1
        got_q.delete();
        send_frame(1000, 3);
        k = 0;
        while (got_q.size() < N && k < 400) begin
            k++;
            ser_ready = pat[k % 4];
            tick();
        end
        chk("bp_count", got_q.size(), N);
        ser_ready = 1'b1;
        chk("bp_w0", got_q[0], 1000);
        chk("bp_w1", got_q[1], 1003);
        chk("bp_w63", got_q[63], 1189);
        wait_idle(50);

        // back-to-back frames 3 cycles apart
        got_q.delete();
        send_frame(200, 1);
        tick();
        tick();
        send_frame(300, 1);
        wait_words(2 * N, 400, "b2b_count");
        chk("b2b_w63", got_q[63], 263);
        chk("b2b_w64", got_q[64], 300);
        chk("b2b_w127", got_q[127], 363);
        chk("b2b_busy", busy, 0);

        // overflow with downstream stalled
        got_q.delete();
        ser_ready = 1'b0;
        send_frame(400, 1);
        send_frame(500, 1);
        send_frame(600, 1);
        chk("ovf_set", overflow, 1);
        ser_ready = 1'b1;
        wait_words(2 * N, 400, "ovf_count");
        chk("ovf_w0", got_q[0], 400);
        chk("ovf_w64", got_q[64], 500);
        chk("ovf_w127", got_q[127], 563);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
        wait_idle(50);

        // par_start in the cycle of the last transfer, both banks full
        got_q.delete();
        send_frame(700, 1);
        send_frame(800, 1);
        k = 0;
        while (!(ser_valid && ser_last && ser_data == 28'd763) && k < 200) begin
            tick();
            k++;
        end
        chk("edge_reach_last", ser_data, 763);
        send_frame(900, 1);
        chk("edge_ovf", overflow, 1);
        wait_words(2 * N, 400, "edge_count");
        tick();
        chk("edge_w64", got_q[64], 800);
        chk("edge_total", got_q.size(), 2 * N);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        wait_idle(50);

        // reset mid-stream at word 20
        send_frame(1100, 1);
        k = 0;
        while (!(ser_valid && ser_data == 28'd1120) && k < 200) begin
            tick();
            k++;
        end
        chk("rst_reach_w20", ser_data, 1120);
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", ser_valid, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        got_q.delete();
        send_frame(1200, 1);
        tick();
        chk("rst_new_first", ser_first, 1);
        chk("rst_new_data", ser_data, 1200);
        wait_words(N, 200, "rst_new_count");
        chk("rst_new_w63", got_q[63], 1263);
        wait_idle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
